// File: rtl/compare_event_tracker_if.sv
// Handshake bundle between a magnitude comparator and compare_event_tracker.
interface compare_event_tracker_if #(
  parameter int unsigned CNT_W = 8
);
  logic             inValid;
  logic             equal;
  logic             greaterThan;
  logic             lessThan;
  logic             clearCounts;
  logic [1:0]       state;
  logic             stateValid;
  logic             crossUp;
  logic             crossDown;
  logic [CNT_W-1:0] upCount;
  logic [CNT_W-1:0] downCount;
  logic             errFlag;

  modport master (
    output inValid, equal, greaterThan, lessThan, clearCounts,
    input  state, stateValid, crossUp, crossDown, upCount, downCount, errFlag
  );

  modport slave (
    input  inValid, equal, greaterThan, lessThan, clearCounts,
    output state, stateValid, crossUp, crossDown, upCount, downCount, errFlag
  );
endinterface

// File: rtl/compare_event_tracker.sv
// Debounces comparator flags into LOW/EQ/HIGH, emits crossing pulses and saturating counts.
// Optional idle fallback to UNKNOWN: define COMPARE_EVENT_TRACKER_TIMEOUT_EN.
module compare_event_tracker #(
  parameter int unsigned DEBOUNCE = 3,
  parameter int unsigned CNT_W    = 8,
  parameter int unsigned TIMEOUT  = 16
) (
  input  logic                    clk,
  input  logic                    reset_n,
  compare_event_tracker_if.slave  bus
);

  localparam int unsigned RUN_W  = 4;
  localparam int unsigned IDLE_W = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    ST_UNKNOWN = 2'b00,
    ST_LOW     = 2'b01,
    ST_EQ      = 2'b10,
    ST_HIGH    = 2'b11
  } cls_e;

  if (DEBOUNCE < 1 || DEBOUNCE > 15 || TIMEOUT < 1) begin : g_param_check
    $error("compare_event_tracker: DEBOUNCE must be 1..15 and TIMEOUT >= 1");
  end

  cls_e             state_q, state_d;
  cls_e             cand_q, cand_d;
  logic [RUN_W-1:0] run_q, run_d;
  logic [CNT_W-1:0] up_q, up_d;
  logic [CNT_W-1:0] down_q, down_d;
  logic             err_q, err_d;
  logic             cross_up_q, cross_up_d;
  logic             cross_down_q, cross_down_d;
  logic             state_valid_q, state_valid_d;
  cls_e             sample_cls;
  logic             sample_legal;
`ifdef COMPARE_EVENT_TRACKER_TIMEOUT_EN
  logic [IDLE_W-1:0] idle_q, idle_d;
`endif

  // Classify the one-hot comparator flags
  always_comb begin
    sample_cls   = ST_UNKNOWN;
    sample_legal = 1'b0;
    unique case ({bus.lessThan, bus.equal, bus.greaterThan})
      3'b100:  begin sample_cls = ST_LOW;  sample_legal = 1'b1; end
      3'b010:  begin sample_cls = ST_EQ;   sample_legal = 1'b1; end
      3'b001:  begin sample_cls = ST_HIGH; sample_legal = 1'b1; end
      default: begin sample_cls = ST_UNKNOWN; sample_legal = 1'b0; end
    endcase
  end

  // Debounce, crossing detection and counters
  always_comb begin
    state_d      = state_q;
    cand_d       = cand_q;
    run_d        = run_q;
    up_d         = up_q;
    down_d       = down_q;
    err_d        = err_q;
    cross_up_d   = 1'b0;
    cross_down_d = 1'b0;
`ifdef COMPARE_EVENT_TRACKER_TIMEOUT_EN
    idle_d       = idle_q;
`endif

    if (bus.inValid && !sample_legal) begin
      err_d = 1'b1;
    end

    if (bus.inValid && sample_legal) begin
      if (sample_cls == state_q) begin
        cand_d = state_q;
        run_d  = '0;
      end else begin
        if (sample_cls == cand_q) begin
          run_d = (run_q >= RUN_W'(DEBOUNCE)) ? RUN_W'(DEBOUNCE) : run_q + RUN_W'(1);
        end else begin
          run_d = RUN_W'(1);
        end
        cand_d = sample_cls;
        // The run that reaches DEBOUNCE commits the candidate this edge
        if (run_d == RUN_W'(DEBOUNCE)) begin
          state_d      = sample_cls;
          run_d        = '0;
          cross_up_d   = (sample_cls == ST_HIGH) && (state_q == ST_LOW || state_q == ST_EQ);
          cross_down_d = (sample_cls == ST_LOW) && (state_q == ST_HIGH || state_q == ST_EQ);
        end
      end
    end

`ifdef COMPARE_EVENT_TRACKER_TIMEOUT_EN
    // Long idle stretch forgets the debounced state without a pulse
    if (bus.inValid) begin
      idle_d = '0;
    end else if (idle_q == IDLE_W'(TIMEOUT - 1)) begin
      idle_d  = '0;
      state_d = ST_UNKNOWN;
      cand_d  = ST_UNKNOWN;
      run_d   = '0;
    end else begin
      idle_d = idle_q + IDLE_W'(1);
    end
`endif

    if (cross_up_d && (up_q != {CNT_W{1'b1}})) begin
      up_d = up_q + CNT_W'(1);
    end
    if (cross_down_d && (down_q != {CNT_W{1'b1}})) begin
      down_d = down_q + CNT_W'(1);
    end
    if (bus.clearCounts) begin
      up_d   = '0;
      down_d = '0;
      err_d  = 1'b0;
    end

    state_valid_d = (state_d != ST_UNKNOWN);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= ST_UNKNOWN;
      cand_q        <= ST_UNKNOWN;
      run_q         <= '0;
      up_q          <= '0;
      down_q        <= '0;
      err_q         <= 1'b0;
      cross_up_q    <= 1'b0;
      cross_down_q  <= 1'b0;
      state_valid_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      cand_q        <= cand_d;
      run_q         <= run_d;
      up_q          <= up_d;
      down_q        <= down_d;
      err_q         <= err_d;
      cross_up_q    <= cross_up_d;
      cross_down_q  <= cross_down_d;
      state_valid_q <= state_valid_d;
    end
  end

`ifdef COMPARE_EVENT_TRACKER_TIMEOUT_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      idle_q <= '0;
    end else begin
      idle_q <= idle_d;
    end
  end
`endif

  assign bus.state      = state_q;
  assign bus.stateValid = state_valid_q;
  assign bus.crossUp    = cross_up_q;
  assign bus.crossDown  = cross_down_q;
  assign bus.upCount    = up_q;
  assign bus.downCount  = down_q;
  assign bus.errFlag    = err_q;

endmodule

// File: tb/tb_compare_event_tracker.sv
// Randomized bench for compare_event_tracker: two configurations against a behavioural model.
module tb_compare_event_tracker;

  localparam int TIMEOUT = 16;
  localparam bit [2:0] L = 3'b100;
  localparam bit [2:0] E = 3'b010;
  localparam bit [2:0] H = 3'b001;

  logic       clk     = 1'b0;
  logic       reset_n = 1'b1;
  logic       iv      = 1'b0;
  logic [2:0] f       = 3'b000;
  logic       clr     = 1'b0;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  compare_event_tracker_if #(.CNT_W(8)) ifa ();
  compare_event_tracker_if #(.CNT_W(2)) ifb ();

  assign ifa.inValid = iv;  assign ifa.lessThan = f[2]; assign ifa.equal = f[1];
  assign ifa.greaterThan = f[0]; assign ifa.clearCounts = clr;
  assign ifb.inValid = iv;  assign ifb.lessThan = f[2]; assign ifb.equal = f[1];
  assign ifb.greaterThan = f[0]; assign ifb.clearCounts = clr;

  compare_event_tracker #(.DEBOUNCE(3), .CNT_W(8), .TIMEOUT(TIMEOUT)) dut_a (
    .clk(clk), .reset_n(reset_n), .bus(ifa));
  compare_event_tracker #(.DEBOUNCE(1), .CNT_W(2), .TIMEOUT(TIMEOUT)) dut_b (
    .clk(clk), .reset_n(reset_n), .bus(ifb));

  // Model state: st/cand use 0 UNKNOWN, 1 LOW, 2 EQ, 3 HIGH
  typedef struct {
    int st; int cand; int run; int up; int down; int idle;
    int err; int cu; int cd;
  } mdl_t;

  mdl_t ma, mb;

  function automatic mdl_t step(mdl_t m, int deb, int cmax,
                                logic v, logic [2:0] fl, logic c);
    mdl_t n = m;
    int cls;
    n.cu = 0; n.cd = 0;
    cls = (fl == L) ? 1 : (fl == E) ? 2 : (fl == H) ? 3 : 0;
    if (v) begin
      n.idle = 0;
      if (cls == 0) n.err = 1;
      else if (cls == m.st) begin n.cand = m.st; n.run = 0; end
      else begin
        if (cls == m.cand) n.run = (m.run + 1 > deb) ? deb : m.run + 1;
        else begin n.cand = cls; n.run = 1; end
        if (n.run == deb) begin
          n.st = cls; n.run = 0;
          n.cu = (cls == 3 && (m.st == 1 || m.st == 2)) ? 1 : 0;
          n.cd = (cls == 1 && (m.st == 3 || m.st == 2)) ? 1 : 0;
        end
      end
    end else begin
`ifdef COMPARE_EVENT_TRACKER_TIMEOUT_EN
      n.idle = m.idle + 1;
      if (n.idle == TIMEOUT) begin n.st = 0; n.cand = 0; n.run = 0; n.idle = 0; end
`endif
    end
    if (n.cu == 1 && n.up < cmax) n.up = n.up + 1;
    if (n.cd == 1 && n.down < cmax) n.down = n.down + 1;
    if (c) begin n.up = 0; n.down = 0; n.err = 0; end
    return n;
  endfunction

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ma <= '{default: 0};
      mb <= '{default: 0};
    end else begin
      ma <= step(ma, 3, 255, iv, f, clr);
      mb <= step(mb, 1, 3, iv, f, clr);
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Every-cycle comparison of both DUTs against the model
  always @(negedge clk) begin
    chk("a_state", 32'(ifa.state), 32'(ma.st));
    chk("a_valid", 32'(ifa.stateValid), 32'(ma.st != 0));
    chk("a_up_pulse", 32'(ifa.crossUp), 32'(ma.cu));
    chk("a_down_pulse", 32'(ifa.crossDown), 32'(ma.cd));
    chk("a_up_count", 32'(ifa.upCount), 32'(ma.up));
    chk("a_down_count", 32'(ifa.downCount), 32'(ma.down));
    chk("a_err", 32'(ifa.errFlag), 32'(ma.err));
    chk("b_state", 32'(ifb.state), 32'(mb.st));
    chk("b_valid", 32'(ifb.stateValid), 32'(mb.st != 0));
    chk("b_up_pulse", 32'(ifb.crossUp), 32'(mb.cu));
    chk("b_down_pulse", 32'(ifb.crossDown), 32'(mb.cd));
    chk("b_up_count", 32'(ifb.upCount), 32'(mb.up));
    chk("b_down_count", 32'(ifb.downCount), 32'(mb.down));
    chk("b_err", 32'(ifb.errFlag), 32'(mb.err));
  end

  task automatic cyc(input logic v, input logic [2:0] fl, input logic c);
    @(negedge clk);
    iv = v; f = fl; clr = c;
  endtask

  task automatic settle();
    cyc(1'b0, 3'b000, 1'b0);
  endtask

  initial begin
    logic [2:0] cur;
    #1 reset_n = 1'b0;
    repeat (3) @(negedge clk);
    #2 reset_n = 1'b1;

    // Reset state
    chk("rst_state", 32'(ifa.state), 0);
    chk("rst_valid", 32'(ifa.stateValid), 0);
    chk("rst_counts", 32'({ifa.upCount, ifa.downCount}), 0);
    chk("rst_err", 32'(ifa.errFlag), 0);

    // First LOW run: no pulse from UNKNOWN
    cyc(1, L, 0); cyc(1, L, 0); cyc(1, L, 0);
    chk("low_pending", 32'(ifa.state), 0);
    settle();
    chk("low_state", 32'(ifa.state), 1);
    chk("low_valid", 32'(ifa.stateValid), 1);
    chk("low_no_pulse", 32'({ifa.crossUp, ifa.crossDown}), 0);

    // LOW -> HIGH
    cyc(1, H, 0); cyc(1, H, 0); cyc(1, H, 0);
    chk("high_pending", 32'(ifa.state), 1);
    settle();
    chk("high_state", 32'(ifa.state), 3);
    chk("high_pulse", 32'(ifa.crossUp), 1);
    chk("high_upcount", 32'(ifa.upCount), 1);
    settle();
    chk("high_pulse_once", 32'(ifa.crossUp), 0);

    // Interrupted run restarts
    cyc(1, L, 0); cyc(1, L, 0); cyc(1, H, 0);
    cyc(1, L, 0); cyc(1, L, 0); cyc(1, L, 0);
    chk("interrupt_pending", 32'(ifa.state), 3);
    settle();
    chk("interrupt_state", 32'(ifa.state), 1);
    chk("interrupt_pulse", 32'(ifa.crossDown), 1);
    chk("interrupt_downcount", 32'(ifa.downCount), 1);

    // Idle gap pauses the run
    cyc(1, H, 0);
    repeat (5) cyc(0, H, 0);
    cyc(1, H, 0); cyc(1, H, 0);
    chk("gap_pending", 32'(ifa.state), 1);
    settle();
    chk("gap_state", 32'(ifa.state), 3);
    chk("gap_upcount", 32'(ifa.upCount), 2);

    // Illegal flags
    cyc(1, 3'b110, 0);
    settle();
    chk("illegal_err", 32'(ifa.errFlag), 1);
    chk("illegal_state", 32'(ifa.state), 3);

    // Clear wins over a simultaneous increment
    cyc(1, L, 0); cyc(1, L, 0); cyc(1, L, 0);
    cyc(1, H, 0); cyc(1, H, 0); cyc(1, H, 1);
    settle();
    chk("clr_pulse", 32'(ifa.crossUp), 1);
    chk("clr_upcount", 32'(ifa.upCount), 0);
    chk("clr_downcount", 32'(ifa.downCount), 0);
    chk("clr_err", 32'(ifa.errFlag), 0);

    // DEBOUNCE=1, CNT_W=2 saturation over 5 round trips
    cyc(0, 3'b000, 1);
    for (int i = 0; i < 5; i++) begin
      cyc(1, L, 0); cyc(1, H, 0);
    end
    settle();
    chk("sat_upcount", 32'(ifb.upCount), 3);
    chk("sat_downcount", 32'(ifb.downCount), 3);

    // Reset mid-run aborts it
    cyc(1, L, 0); cyc(1, L, 0);
    @(negedge clk); #2 reset_n = 1'b0; iv = 1'b0;
    #1 chk("midrst_state", 32'(ifa.state), 0);
    @(negedge clk); #2 reset_n = 1'b1;
    cyc(1, L, 0);
    settle();
    chk("midrst_no_commit", 32'(ifa.state), 0);
    chk("midrst_no_pulse", 32'(ifa.crossDown), 0);

`ifdef COMPARE_EVENT_TRACKER_TIMEOUT_EN
    cyc(1, L, 0); cyc(1, L, 0); cyc(1, L, 0);
    repeat (16) cyc(0, 3'b000, 0);
    chk("timeout_pending", 32'(ifa.state), 1);
    settle();
    chk("timeout_state", 32'(ifa.state), 0);
    chk("timeout_valid", 32'(ifa.stateValid), 0);
`endif

    // Randomized traffic with persistent classes, occasional illegal/clear/reset
    cur = L;
    for (int i = 0; i < 4000; i++) begin
      logic [2:0] fl;
      if ($urandom_range(0, 3) == 0) begin
        case ($urandom_range(0, 2))
          0: cur = L;
          1: cur = E;
          default: cur = H;
        endcase
      end
      fl = cur;
      if ($urandom_range(0, 29) == 0) fl = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 799) == 0) begin
        @(negedge clk); #2 reset_n = 1'b0;
        @(negedge clk); #2 reset_n = 1'b1;
      end else if ($urandom_range(0, 299) == 0) begin
        repeat (20) cyc(0, fl, 0);
      end else begin
        cyc(($urandom_range(0, 9) < 7) ? 1'b1 : 1'b0, fl,
            ($urandom_range(0, 99) == 0) ? 1'b1 : 1'b0);
      end
    end
    settle();
    settle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/compare_event_tracker.md
Name: compare_event_tracker

Overview:
- Downstream consumer of the 4-bit magnitude comparator's equal/greaterThan/lessThan outputs, sampled once per clock when inValid is high.
- Debounces the comparison result into a stable LOW/EQ/HIGH state.
- Emits one-cycle crossing pulses and keeps saturating crossing counters.
- Flags illegal (non-one-hot) comparator outputs.

Parameters:
- DEBOUNCE, 3, consecutive valid samples of a new class needed to change state (legal range 1..15).
- CNT_W, 8, width of each crossing counter.
- TIMEOUT, 16, idle cycles before falling back to UNKNOWN (used only with the optional feature).

Ports:
- clk  input  1  rising-edge clock
- reset_n  input  1  asynchronous active-low reset
- inValid  input  1  comparator flags are valid this cycle
- equal  input  1  comparator a==b
- greaterThan  input  1  comparator a>b
- lessThan  input  1  comparator a<b
- clearCounts  input  1  synchronous clear of counters and errFlag
- state  output  2  00 UNKNOWN, 01 LOW, 10 EQ, 11 HIGH
- stateValid  output  1  state != UNKNOWN
- crossUp  output  1  one-cycle pulse on entry to HIGH from LOW or EQ
- crossDown  output  1  one-cycle pulse on entry to LOW from HIGH or EQ
- upCount  output  CNT_W  number of crossUp events, saturating
- downCount  output  CNT_W  number of crossDown events, saturating
- errFlag  output  1  sticky: illegal flag combination seen

Behaviour:
- Reset (async assert, sync release): state=UNKNOWN, stateValid=0, crossUp=crossDown=0, upCount=downCount=0, errFlag=0, candidate=UNKNOWN, run=0.
- All outputs are registered.
- Sample classification, only when inValid=1:
  - {lessThan,equal,greaterThan} = 100 → LOW; 010 → EQ; 001 → HIGH.
  - Any other combination is illegal. It sets errFlag, is otherwise ignored, and leaves candidate/run unchanged.
- inValid=0: no change to candidate, run or state; the debounce is paused, not reset.
- Legal sample with class == state: candidate := state, run := 0.
- Legal sample with class != state:
  - If class == candidate, run := run+1, saturating at DEBOUNCE.
  - Otherwise candidate := class, run := 1.
- State update:
  - On the edge that accepts the DEBOUNCE-th consecutive qualifying sample, state := candidate and run := 0. The new state is visible the following cycle.
  - With DEBOUNCE=1 the state follows every legal sample, with one-cycle latency.
- Pulses, asserted for exactly the cycle after the state update:
  - crossUp when the new state is HIGH and the old state is LOW or EQ.
  - crossDown when the new state is LOW and the old state is HIGH or EQ.
  - No pulse for UNKNOWN→any, or for any transition into EQ.
- Counters increment on the same edge the pulse is registered and saturate at 2^CNT_W-1 (no wrap).
- clearCounts=1:
  - Clears upCount, downCount and errFlag on the next edge.
  - Takes priority over a simultaneous increment or error: the result is 0, but the crossing pulse is still emitted.
  - Does not affect state, candidate or run.
- Reset asserted mid-debounce aborts the run immediately; no pulse is generated.

Optional Feature:
- Macro: COMPARE_EVENT_TRACKER_TIMEOUT_EN.
- Defined:
  - An idle counter counts consecutive cycles with inValid=0 and clears on any inValid=1 cycle.
  - When it reaches TIMEOUT: state := UNKNOWN, candidate := UNKNOWN, run := 0. No pulse is emitted and counters are unaffected.
  - The next qualified run re-enters a state without a pulse.
- Not defined: no idle counter; state holds indefinitely while inValid=0.

Test Plan:
- Reset, then 3 valid LOW samples → state=01 and stateValid=1 the cycle after the 3rd sample; crossUp=crossDown=0; counts 0.
- From LOW, 3 valid HIGH samples → state=11 the cycle after the 3rd; crossUp=1 for exactly one cycle; upCount=1.
- From HIGH, pattern LOW,LOW,HIGH,LOW,LOW,LOW → state stays HIGH until the final LOW is accepted, then state=01, crossDown pulse, downCount=1.
- HIGH,(inValid=0 ×5),HIGH,HIGH starting from LOW → transitions to HIGH after the 3rd valid HIGH; the gap does not reset the run.
- Flags 110 with inValid=1 → errFlag=1 next cycle, state unchanged; clearCounts asserted together with a crossUp-producing sample → upCount=0, errFlag=0, crossUp still pulses.
- CNT_W=2, 5 LOW↔HIGH round trips → upCount=downCount=3 (saturated); with COMPARE_EVENT_TRACKER_TIMEOUT_EN and TIMEOUT=16, 16 idle cycles → state=00, stateValid=0.
